vx_commit_arb: RTL and testbench
================================

Name: vx_commit_arb

Overview:
- Commit-side arbiter feeding the issue stage's writeback port for one issue slot.
- Collects result packets from the ALU, LSU, FPU and SFU commit outputs and grants one per cycle, round-robin.
- Registers the granted packet and drives it as a single writeback stream, which the register file and operand logic consume.
- Instantiate once per issue slot, ISSUE_WIDTH instances in total.

Parameters:
- NUM_SRCS, 4, number of execute-unit sources; index 0=ALU, 1=LSU, 2=FPU, 3=SFU.
- NUM_THREADS, 4, lanes per packet.
- XLEN, 32, data width per lane.
- NW_BITS, 2, warp-id width.
- NR_BITS, 6, register-id width.
- UUID_W, 44, instruction uuid width.
- DATAW, derived: UUID_W+NW_BITS+NUM_THREADS+NR_BITS+1+NUM_THREADS*XLEN+1, packet width.

Ports:
- clk, in, 1, clock.
- reset, in, 1, asynchronous, active-low reset.
- in_valid, in, NUM_SRCS, per-source packet valid.
- in_ready, out, NUM_SRCS, per-source accept (one-hot or zero).
- in_data, in, NUM_SRCS*DATAW, packed packets, source i at bits [i*DATAW +: DATAW]. Field order MSB to LSB: uuid, wid, tmask, rd, wb, data, eop.
- out_valid, out, 1, writeback valid.
- out_uuid, out, UUID_W, writeback uuid.
- out_wid, out, NW_BITS, writeback warp id.
- out_tmask, out, NUM_THREADS, writeback thread mask.
- out_rd, out, NR_BITS, writeback destination register.
- out_data, out, NUM_THREADS*XLEN, writeback data.
- out_eop, out, 1, last packet of the instruction.

Behaviour:
- Reset (asserted low, async):
  - out_valid=0; all other outputs 0.
  - Priority pointer=0; no packet lock.
  - Reset mid-packet-sequence discards the lock and any registered packet.
  - in_ready is 0 while reset is asserted.
- Writeback has no backpressure. The output register loads every cycle; out_valid is high exactly one cycle per forwarded packet.
- Grant:
  - Combinational from in_valid, pointer and lock.
  - in_ready[i]=1 only for the granted source; at most one bit set.
  - Fire = in_valid[i] & in_ready[i].
- Round-robin:
  - Search starts at the pointer index and wraps modulo NUM_SRCS.
  - After a fire from source i with eop=1, pointer <= (i+1) mod NUM_SRCS.
  - Pointer is unchanged on idle cycles.
- Packet lock:
  - A fire with eop=0 locks the grant to that source.
  - Only that source may be granted until it fires with eop=1.
  - Other sources stall while locked, even if the locked source is not valid.
- Latency: fire in cycle N means the output fields are valid in cycle N+1. Throughput is 1 packet per cycle.
- wb=0 packets:
  - Still consumed, with the same grant and lock rules.
  - out_valid stays 0 for that cycle.
  - The out_* data fields still update; they are don't-care.
- rd=0 with wb=1 is forwarded unchanged; the register file ignores r0.
- No valid input: out_valid=0 next cycle.
- Data fields are captured only on fire; in_data is not sampled otherwise.
- Sources must hold in_data stable while in_valid=1 and in_ready=0. The block does not check this.

Optional Feature:
- Macro: COMMIT_PERF_EN.
- Defined: adds ports perf_commits (out, 64) and perf_stalls (out, 64).
  - perf_commits increments on every fire with eop=1, including wb=0 fires.
  - perf_stalls increments by 1 each cycle in which in_valid has at least one bit set that is not granted. It counts cycles, not sources.
  - Both counters clear on reset and wrap at 2^64.
- Undefined: both ports and counters are absent; all other behaviour is identical.

Test Plan:
- Reset release, all in_valid=0 for 10 cycles -> out_valid=0 throughout; in_ready=0000.
- in_valid=1111 held, every packet eop=1 -> grants 0,1,2,3,0,... one per cycle; out_valid=1 every cycle from cycle 2. Each out_uuid matches its granted source one cycle later.
- LSU sends 3 packets with eop=0,0,1 while ALU is valid throughout -> ALU in_ready=0 for 3 fires; ALU is granted on the 4th cycle. The LSU packets appear back-to-back on the output.
- SFU packet with wb=0, eop=1 while ALU idle -> sfu in_ready=1 in one cycle; out_valid stays 0; pointer becomes 0. With COMMIT_PERF_EN, perf_commits increments by 1.
- reset pulled low mid LSU sequence (after eop=0 fire) -> out_valid=0 immediately. After release, in_valid=0101 grants ALU first: pointer is 0 and the lock is cleared.
- COMMIT_PERF_EN, in_valid=0011 for 4 cycles, all eop=1 -> perf_commits=4, perf_stalls=4.

Source files
------------

// File: rtl/vx_commit_arb.sv
// Commit-side round-robin arbiter: picks one execute-unit result per cycle and
// registers it as the writeback stream. Optional perf counters under COMMIT_PERF_EN.
module vx_commit_arb #(
   parameter int NUM_SRCS    = 4,
   parameter int NUM_THREADS = 4,
   parameter int XLEN        = 32,
   parameter int NW_BITS     = 2,
   parameter int NR_BITS     = 6,
   parameter int UUID_W      = 44,
   parameter int DATAW       = UUID_W + NW_BITS + NUM_THREADS + NR_BITS + 1 + NUM_THREADS * XLEN + 1
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic [NUM_SRCS-1:0]           in_valid,
   output logic [NUM_SRCS-1:0]           in_ready,
   input  logic [NUM_SRCS*DATAW-1:0]     in_data,
   output logic                          out_valid,
   output logic [UUID_W-1:0]             out_uuid,
   output logic [NW_BITS-1:0]            out_wid,
   output logic [NUM_THREADS-1:0]        out_tmask,
   output logic [NR_BITS-1:0]            out_rd,
   output logic [NUM_THREADS*XLEN-1:0]   out_data,
   output logic                          out_eop
`ifdef COMMIT_PERF_EN
   ,
   output logic [63:0]                   perf_commits,
   output logic [63:0]                   perf_stalls
`endif
);

   localparam int PTR_W     = (NUM_SRCS > 1) ? $clog2(NUM_SRCS) : 1;
   localparam int DATA_LSB  = 1;
   localparam int WB_LSB    = DATA_LSB + NUM_THREADS * XLEN;
   localparam int RD_LSB    = WB_LSB + 1;
   localparam int TMASK_LSB = RD_LSB + NR_BITS;
   localparam int WID_LSB   = TMASK_LSB + NUM_THREADS;
   localparam int UUID_LSB  = WID_LSB + NW_BITS;

   // Handshake: a source's packet transfers in the cycle where in_valid[i] and
   // in_ready[i] are both high; the source must hold in_data until then.
   logic [PTR_W-1:0]    ptr_q, ptr_n;
   logic                locked_q, locked_n;
   logic [PTR_W-1:0]    lock_src_q, lock_src_n;
   logic [NUM_SRCS-1:0] grant;
   logic [PTR_W-1:0]    grant_idx;
   int                  scan_idx;
   logic                fire;
   logic [DATAW-1:0]    sel_pkt;
   logic                sel_eop;
   logic                sel_wb;

   // State register: round-robin pointer and packet lock.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         ptr_q      <= '0;
         locked_q   <= 1'b0;
         lock_src_q <= '0;
      end else begin
         ptr_q      <= ptr_n;
         locked_q   <= locked_n;
         lock_src_q <= lock_src_n;
      end
   end

   // Scan runs from the far end back to the pointer so the pointer index wins.
   always_comb begin
      grant     = '0;
      grant_idx = '0;
      scan_idx  = 0;
      if (locked_q) begin
         if (in_valid[lock_src_q]) begin
            grant[lock_src_q] = 1'b1;
            grant_idx         = lock_src_q;
         end
      end else begin
         for (int k = NUM_SRCS - 1; k >= 0; k--) begin
            scan_idx = (int'(ptr_q) + k) % NUM_SRCS;
            if (in_valid[scan_idx]) begin
               grant           = '0;
               grant[scan_idx] = 1'b1;
               grant_idx       = PTR_W'(scan_idx);
            end
         end
      end
   end

   assign in_ready = grant & {NUM_SRCS{reset}};
   assign fire     = |(in_valid & in_ready);
   assign sel_pkt  = in_data[grant_idx * DATAW +: DATAW];
   assign sel_eop  = sel_pkt[0];
   assign sel_wb   = sel_pkt[WB_LSB];

   // Next-state: eop releases the lock and advances the pointer past the winner.
   always_comb begin
      ptr_n      = ptr_q;
      locked_n   = locked_q;
      lock_src_n = lock_src_q;
      if (fire) begin
         if (sel_eop) begin
            locked_n = 1'b0;
            ptr_n    = (grant_idx == PTR_W'(NUM_SRCS - 1)) ? '0 : grant_idx + 1'b1;
         end else begin
            locked_n   = 1'b1;
            lock_src_n = grant_idx;
         end
      end
   end

   // Output stage: valid reloads every cycle, fields only on a fire.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         out_valid <= 1'b0;
         out_uuid  <= '0;
         out_wid   <= '0;
         out_tmask <= '0;
         out_rd    <= '0;
         out_data  <= '0;
         out_eop   <= 1'b0;
      end else begin
         out_valid <= fire & sel_wb;
         if (fire) begin
            out_uuid  <= sel_pkt[UUID_LSB +: UUID_W];
            out_wid   <= sel_pkt[WID_LSB +: NW_BITS];
            out_tmask <= sel_pkt[TMASK_LSB +: NUM_THREADS];
            out_rd    <= sel_pkt[RD_LSB +: NR_BITS];
            out_data  <= sel_pkt[DATA_LSB +: NUM_THREADS * XLEN];
            out_eop   <= sel_eop;
         end
      end
   end

`ifdef COMMIT_PERF_EN
   // Stalls count cycles with any waiting-but-ungranted source, not sources.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         perf_commits <= '0;
         perf_stalls  <= '0;
      end else begin
         if (fire && sel_eop) perf_commits <= perf_commits + 64'd1;
         if (|(in_valid & ~in_ready)) perf_stalls <= perf_stalls + 64'd1;
      end
   end
`endif

endmodule

// File: tb/tb_vx_commit_arb.sv
// Directed bench for vx_commit_arb: grant order, packet lock, wb=0, reset, and
// (with COMMIT_PERF_EN) the perf counters.
module tb_vx_commit_arb;

   localparam int NS    = 4;
   localparam int NT    = 4;
   localparam int XLEN  = 32;
   localparam int NW    = 2;
   localparam int NR    = 6;
   localparam int UW    = 44;
   localparam int DW    = NT * XLEN;
   localparam int DATAW = UW + NW + NT + NR + 1 + DW + 1;

   logic                clk = 1'b0;
   logic                reset;
   logic [NS-1:0]       in_valid;
   logic [NS-1:0]       in_ready;
   logic [NS*DATAW-1:0] in_data;
   logic                out_valid;
   logic [UW-1:0]       out_uuid;
   logic [NW-1:0]       out_wid;
   logic [NT-1:0]       out_tmask;
   logic [NR-1:0]       out_rd;
   logic [DW-1:0]       out_data;
   logic                out_eop;
`ifdef COMMIT_PERF_EN
   logic [63:0]         perf_commits;
   logic [63:0]         perf_stalls;
`endif

   vx_commit_arb dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .out_valid(out_valid), .out_uuid(out_uuid), .out_wid(out_wid), .out_tmask(out_tmask),
      .out_rd(out_rd), .out_data(out_data), .out_eop(out_eop)
`ifdef COMMIT_PERF_EN
      , .perf_commits(perf_commits), .perf_stalls(perf_stalls)
`endif
   );

   // Clock / reset
   always #5 clk = ~clk;

   // Source shadows: the packet each source currently presents
   logic [UW-1:0] uuid_s [NS];
   logic          eop_s  [NS];
   logic          wb_s   [NS];

   logic [DATAW-1:0] exp_q[$];
   int               n_vec = 0;
   int               n_err = 0;
   longint           exp_commits = 0;
   longint           exp_stalls  = 0;

   function automatic logic [DATAW-1:0] pkt_of(input int s);
      logic [NT-1:0] tm;
      logic [NR-1:0] rd;
      logic [31:0]   u;
      tm = 4'hF ^ NT'(s);
      rd = (s == 2) ? '0 : NR'(s + 5);
      u  = uuid_s[s][31:0];
      return {uuid_s[s], NW'(s), tm, rd, wb_s[s],
              u ^ 32'hA000_0000, u ^ 32'h0B00_0000, u ^ 32'h00C0_0000, u ^ 32'h000D_0000,
              eop_s[s]};
   endfunction

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, want %0h", tag, obs, exp);
      end
   endtask

   task automatic apply();
      for (int s = 0; s < NS; s++) in_data[s*DATAW +: DATAW] = pkt_of(s);
   endtask

   // Driver: present current in_valid/shadows, check grant, clock, check output.
   task automatic grant_cycle(input string tag, input logic [NS-1:0] exp_ready);
      int               s;
      logic             exp_vld;
      logic [DATAW-1:0] e;
      apply();
      #1;
      check({tag, " in_ready"}, 128'(in_ready), 128'(exp_ready));
      s = -1;
      exp_vld = 1'b0;
      for (int i = 0; i < NS; i++) if (exp_ready[i] && in_valid[i]) s = i;
      if (s >= 0) begin
         if (wb_s[s]) begin
            exp_q.push_back(pkt_of(s));
            exp_vld = 1'b1;
         end
         if (eop_s[s]) exp_commits++;
      end
      if ((in_valid & ~exp_ready) != '0) exp_stalls++;
      @(posedge clk);
      #1;
      check({tag, " out_valid"}, 128'(out_valid), 128'(exp_vld));
      if (exp_vld) begin
         e = exp_q.pop_front();
         check({tag, " uuid"},  128'(out_uuid),  128'(e[DATAW-1 -: UW]));
         check({tag, " wid"},   128'(out_wid),   128'(e[DATAW-UW-1 -: NW]));
         check({tag, " tmask"}, 128'(out_tmask), 128'(e[DATAW-UW-NW-1 -: NT]));
         check({tag, " rd"},    128'(out_rd),    128'(e[DATAW-UW-NW-NT-1 -: NR]));
         check({tag, " data"},  128'(out_data),  128'(e[DW:1]));
         check({tag, " eop"},   128'(out_eop),   128'(e[0]));
      end
      if (s >= 0) uuid_s[s] = uuid_s[s] + 1'b1;
   endtask

   task automatic pulse_reset();
      reset = 1'b0;
      #1;
      check("rst out_valid", 128'(out_valid), 128'(0));
      check("rst in_ready", 128'(in_ready), 128'(0));
      exp_q.delete();
      exp_commits = 0;
      exp_stalls  = 0;
      @(posedge clk);
      #1;
      reset = 1'b1;
   endtask

   initial begin
      reset    = 1'b0;
      in_valid = '0;
      for (int s = 0; s < NS; s++) begin
         uuid_s[s] = UW'(64'h100 * (s + 1));
         eop_s[s]  = 1'b1;
         wb_s[s]   = 1'b1;
      end
      apply();
      repeat (2) @(posedge clk);
      #1;

      // Reset state: outputs zero, no grant even with sources valid
      in_valid = 4'b1111;
      apply();
      #1;
      check("reset in_ready", 128'(in_ready), 128'(0));
      check("reset out_valid", 128'(out_valid), 128'(0));
      check("reset out_uuid", 128'(out_uuid), 128'(0));
      check("reset out_data", 128'(out_data), 128'(0));
      check("reset out_eop", 128'(out_eop), 128'(0));
      in_valid = '0;
      reset    = 1'b1;
      for (int k = 0; k < 10; k++) grant_cycle("idle", 4'b0000);

      // Round robin with all sources valid, eop=1
      in_valid = 4'b1111;
      for (int k = 0; k < 8; k++) grant_cycle("rr", NS'(1 << (k % NS)));

      // Move pointer to LSU, then LSU 3-beat packet while ALU waits
      in_valid = 4'b0001;
      grant_cycle("alu_only", 4'b0001);
      in_valid = 4'b0011;
      eop_s[1] = 1'b0;
      grant_cycle("lock0", 4'b0010);
      grant_cycle("lock1", 4'b0010);
      eop_s[1] = 1'b1;
      grant_cycle("lock2", 4'b0010);
      grant_cycle("after_lock", 4'b0001);

      // SFU wb=0 eop=1: consumed, no writeback, pointer wraps to ALU
      in_valid = 4'b1000;
      wb_s[3]  = 1'b0;
      grant_cycle("sfu_nowb", 4'b1000);
`ifdef COMMIT_PERF_EN
      check("sfu perf_commits", 128'(perf_commits), 128'(exp_commits));
`endif
      wb_s[3]  = 1'b1;
      in_valid = 4'b1111;
      grant_cycle("ptr_wrap", 4'b0001);

      // Lock holds even while the locked source drops valid
      in_valid = 4'b0100;
      eop_s[2] = 1'b0;
      grant_cycle("fpu_lock", 4'b0100);
      in_valid = 4'b0011;
      grant_cycle("locked_stall", 4'b0000);
      in_valid = 4'b0111;
      eop_s[2] = 1'b1;
      grant_cycle("fpu_end", 4'b0100);
      in_valid = 4'b0011;
      grant_cycle("wrap_alu", 4'b0001);

      // Reset mid packet: lock and pointer cleared
      in_valid = 4'b0010;
      eop_s[1] = 1'b0;
      grant_cycle("mid_seq", 4'b0010);
      pulse_reset();
      eop_s[1] = 1'b1;
      in_valid = 4'b0101;
      grant_cycle("post_rst", 4'b0001);

      // Two competing sources for 4 cycles from a clean reset
      in_valid = '0;
      pulse_reset();
      in_valid = 4'b0011;
      for (int k = 0; k < 4; k++) grant_cycle("pair", (k % 2 == 0) ? 4'b0001 : 4'b0010);
`ifdef COMMIT_PERF_EN
      check("perf_commits", 128'(perf_commits), 128'(exp_commits));
      check("perf_stalls", 128'(perf_stalls), 128'(exp_stalls));
      check("perf_commits abs", 128'(perf_commits), 128'(4));
      check("perf_stalls abs", 128'(perf_stalls), 128'(4));
`endif
      in_valid = '0;
      grant_cycle("tail", 4'b0000);
      check("queue empty", 128'(exp_q.size()), 128'(0));

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
